// File: rtl/serial_minuend_restore.sv
// Bit-serial adder rebuilding minuend = diff + sub, LSB first, with start/busy/done handshake.
// Optional SERIAL_ADD_SUB_EN adds a mode port selecting add (0) or borrow-chain subtract (1).
module serial_minuend_restore #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] diff_in,
    input  logic [WIDTH-1:0] sub_in,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, carry_d;
    logic             bit_a, bit_b, bit_s;

`ifdef SERIAL_ADD_SUB_EN
    logic mode_q;
`else
    localparam logic mode_q = 1'b0;
`endif

    always_comb begin
        bit_a = a_q[0];
        bit_b = b_q[0];
        bit_s = bit_a ^ bit_b ^ carry_q;
        if (mode_q) begin
            carry_d = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & carry_q);
        end else begin
            carry_d = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));
        end
        // Result fills from the MSB so it is aligned after WIDTH shifts
        res_d = {bit_s, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum_out   <= '0;
            carry_out <= 1'b0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
`ifdef SERIAL_ADD_SUB_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= diff_in;
                        b_q     <= sub_in;
`ifdef SERIAL_ADD_SUB_EN
                        mode_q  <= mode;
`endif
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        sum_out   <= res_d;
                        carry_out <= carry_d;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_minuend_restore.sv
// Directed bench for serial_minuend_restore (WIDTH=8); subtract vectors run when
// SERIAL_ADD_SUB_EN is defined.
module tb_serial_minuend_restore;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] diff_in = '0;
    logic [WIDTH-1:0] sub_in = '0;
    logic             mode = 1'b0;
    logic             busy, done, carry_out;
    logic [WIDTH-1:0] sum_out;

    int compared = 0;
    int mismatched = 0;
    logic [WIDTH-1:0] prev_sum = '0;
    logic             prev_c = 1'b0;

    serial_minuend_restore #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .diff_in   (diff_in),
        .sub_in    (sub_in),
`ifdef SERIAL_ADD_SUB_EN
        .mode      (mode),
`endif
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation; start is accepted at the next edge. poke re-asserts start mid-busy.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] s,
                          input logic m, input logic poke,
                          input logic [WIDTH-1:0] exp_sum, input logic exp_c);
        int busy_cycles;
        start = 1'b1; diff_in = d; sub_in = s; mode = m;
        tick();
        start = 1'b0; diff_in = ~d; sub_in = ~s; mode = ~m;
        busy_cycles = 0;
        check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        check({tag, "_hold_sum"}, {24'd0, sum_out}, {24'd0, prev_sum});
        check({tag, "_hold_c"}, {31'd0, carry_out}, {31'd0, prev_c});
        for (int i = 0; i < WIDTH; i++) begin
            if (busy) busy_cycles++;
            if (busy && done) check({tag, "_busy_and_done"}, 32'd1, 32'd0);
            if (poke && i == 3) begin
                start = 1'b1; diff_in = 8'h55; sub_in = 8'h11;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, busy_cycles, WIDTH);
        check({tag, "_done"}, {30'd0, busy, done}, 32'd1);
        check({tag, "_sum"}, {24'd0, sum_out}, {24'd0, exp_sum});
        check({tag, "_carry"}, {31'd0, carry_out}, {31'd0, exp_c});
        tick();
        check({tag, "_done_fall"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_sum_held"}, {24'd0, sum_out}, {24'd0, exp_sum});
        prev_sum = exp_sum;
        prev_c = exp_c;
    endtask

    initial begin
        int done_seen;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum_out}, 32'd0);
        check("rst_carry", {31'd0, carry_out}, 32'd0);
        tick();
        tick();
        check("idle_hold", {22'd0, busy, done, carry_out, sum_out}, 32'd0);

        run_op("add_25_13", 8'h25, 8'h13, 1'b0, 1'b0, 8'h38, 1'b0);
        // Back-to-back: the next start lands on the first IDLE edge
        run_op("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("wrap_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("ignore_start", 8'h0F, 8'h01, 1'b0, 1'b1, 8'h10, 1'b0);
        run_op("add_a7_6c", 8'hA7, 8'h6C, 1'b0, 1'b0, 8'h13, 1'b1);

        // Abort during the 4th SHIFT cycle
        start = 1'b1; diff_in = 8'h33; sub_in = 8'h11; mode = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_outputs", {22'd0, busy, done, carry_out, sum_out}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            if (done || busy) done_seen++;
            tick();
        end
        check("abort_no_done", done_seen, 0);
        prev_sum = '0;
        prev_c = 1'b0;
        run_op("after_abort", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0);

        // Reset beats a simultaneous start
        rst = 1'b1; start = 1'b1; diff_in = 8'h01; sub_in = 8'h01;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_wins", {30'd0, busy, done}, 32'd0);
        tick();
        check("rst_wins_idle", {30'd0, busy, done}, 32'd0);
        prev_sum = '0;
        prev_c = 1'b0;

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b1);
        run_op("sub_09_04", 8'h09, 8'h04, 1'b1, 1'b0, 8'h05, 1'b0);
        run_op("add_after_sub", 8'h25, 8'h13, 1'b0, 1'b0, 8'h38, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
